// File: rtl/click_tx.sv
// click_tx: synchronous producer FIFO feeding a two-phase bundled-data
// (click) channel. Words are queued, then launched one at a time. out_data
// settles one cycle before the out_req toggle. A token completes when the
// synchronized acknowledge matches out_req.
module click_tx #(
    parameter int DW          = 2,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_req,
    input  logic          out_ack,
    output logic [7:0]    o_tx_cnt,
    output logic          o_err
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(DEPTH);
    localparam logic [WCNT_W-1:0] TIMEOUT_VAL = WCNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // FIFO storage and bookkeeping
    logic [DW-1:0]     fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              in_ready_q, in_ready_d;

    // Channel side
    state_e            state_q, state_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic              out_req_q, out_req_d;
    logic              ack_meta_q, ack_s_q;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [7:0]        tx_cnt_q, tx_cnt_d;
    logic              err_q, err_d;

    logic              push;
    logic              pop;

    // in_ready comes from a flop, so a pop never reaches it combinationally.
    assign push = in_valid && in_ready_q;

    assign in_ready = in_ready_q;
    assign out_data = out_data_q;
    assign out_req  = out_req_q;
    assign o_tx_cnt = tx_cnt_q;
    assign o_err    = err_q;

    // FIFO pointer and occupancy update; simultaneous push and pop cancel.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        in_ready_d = (count_d != FULL_CNT);
    end

    // Launch FSM: IDLE loads the head word, LOAD toggles req, WAIT awaits ack.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_req_d  = out_req_q;
        wait_cnt_d = wait_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        err_d      = err_q;
        pop        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Ack activity here is ignored. Only WAIT looks at ack_s.
                if (count_q != '0) begin
                    pop        = 1'b1;
                    out_data_d = fifo_mem_q[rd_ptr_q];
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Data has been stable for a full cycle; issue the token now.
                out_req_d  = ~out_req_q;
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // Counter saturates at the limit. The flag is raised but the
                // token is never aborted.
                if (wait_cnt_q == TIMEOUT_VAL) begin
                    err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
                if (ack_s_q == out_req_q) begin
                    tx_cnt_d = tx_cnt_q + 8'd1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers, ack synchronizer and synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_IDLE;
            out_data_q <= '0;
            out_req_q  <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            wait_cnt_q <= '0;
            tx_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_req_q  <= out_req_d;
            ack_meta_q <= out_ack;
            ack_s_q    <= ack_meta_q;
            wait_cnt_q <= wait_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            err_q      <= err_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; empty/full come from the
        // reset pointers and count, so stale entries are never read.
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: doc/click_tx.md
CLICK_TX -- requirements
Module: click_tx

Interface
REQ-001 Parameter DW, default 2, data width of the channel.
REQ-002 Parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-003 Parameter TIMEOUT_CYC, default 16, WAIT cycles before o_err sets.
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port in_data  in  DW  word to send, qualified by in_valid.
REQ-007 Port in_valid  in  1  producer has a word on in_data.
REQ-008 Port in_ready  out  1  FIFO can accept a word this cycle.
REQ-009 Port out_data  out  DW  bundled data to click channel, registered.
REQ-010 Port out_req  out  1  two-phase request; each toggle is one token.
REQ-011 Port out_ack  in  1  two-phase acknowledge from click stage, asynchronous to clk.
REQ-012 Port o_tx_cnt  out  8  completed-transfer count.
REQ-013 Port o_err  out  1  sticky ack-timeout flag.

Function
REQ-014 Push occurs on an edge where in_valid=1 and in_ready=1; in_ready = FIFO not full (registered occupancy, no combinational path from FIFO pop).
REQ-015 Push into a full FIFO shall never occur; in_data while in_ready=0 is ignored.
REQ-016 out_ack shall pass a 2-flop synchronizer (ack_s) before any use; ack_s latency 2 cycles.
REQ-017 FSM states IDLE, LOAD, WAIT.
REQ-018 IDLE: if FIFO non-empty, at edge: out_data <= FIFO head, pop, go to LOAD; else stay.
REQ-019 LOAD: at edge, out_req <= ~out_req, go to WAIT; out_data shall be stable one full cycle before the req toggle (bundled-data setup).
REQ-020 WAIT: when ack_s == out_req, at edge go to IDLE and increment o_tx_cnt.
REQ-021 out_data shall not change outside the IDLE->LOAD transition.
REQ-022 o_tx_cnt wraps 255 -> 0 without flag.
REQ-023 WAIT cycle counter clears on LOAD->WAIT entry; when it reaches TIMEOUT_CYC, o_err <= 1; FSM stays in WAIT until ack arrives (no abort).
REQ-024 o_err is sticky; cleared only by reset.
REQ-025 ack_s changes while not in WAIT are ignored; no state change, no count.
REQ-026 Push and pop on the same edge: occupancy unchanged, both words preserved in order.
REQ-027 Minimum latency push edge E0 -> out_req toggle at E2; throughput one word per (3 + ack round trip) cycles.
REQ-028 Words leave in push order; no loss or duplication.

Reset
REQ-029 While reset=1 at an edge: state IDLE, FIFO empty, out_req=0, out_data=0, sync flops=0, o_tx_cnt=0, o_err=0, WAIT counter=0.
REQ-030 in_ready=0 while reset is asserted; 1 from the first edge after reset deasserts.
REQ-031 Reset mid-WAIT discards the in-flight token and all FIFO contents; the click stage shares reset, so out_req=out_ack=0 afterwards.

Verification
REQ-032 Reset, push 2'b10 at E0 -> out_data=10 after E1, out_req 0->1 after E2; set out_ack=1 -> IDLE within 3 cycles, o_tx_cnt=1.
REQ-033 Then push 2'b11 -> out_data=11, out_req 1->0; out_ack=0 -> o_tx_cnt=2, o_err=0.
REQ-034 out_ack held, push 5 words back-to-back -> first in out_data, four in FIFO, in_ready=0 after the 5th push; toggle ack 5 times -> words emerge in order, o_tx_cnt=5.
REQ-035 out_ack held for 20 cycles in WAIT -> o_err=1 at TIMEOUT_CYC=16; then toggle ack -> transfer completes, o_err stays 1.
REQ-036 Assert reset during WAIT with 2 words queued -> next edge: out_req=0, in_ready=0, o_tx_cnt=0, o_err=0; after release no toggle occurs until a new push.
REQ-037 Toggle out_ack while IDLE with empty FIFO -> no out_req change, o_tx_cnt unchanged.
